// File: rtl/dispatch_scheduler.sv
// In-order dual-slot dispatch scheduler: routes decoded pairs to simple/complex/FP units.
// Optional stall counter enabled by defining DISPATCH_STALL_CNT_EN.
module dispatch_scheduler #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_a_class,
  input  logic [1:0]       in_b_class,
  input  logic [TAG_W-1:0] in_a_tag,
  input  logic [TAG_W-1:0] in_b_tag,
  output logic             sx_valid,
  input  logic             sx_ready,
  output logic [TAG_W-1:0] sx_tag,
  output logic             cx_valid,
  input  logic             cx_ready,
  output logic [TAG_W-1:0] cx_tag,
  output logic             fp_valid,
  input  logic             fp_ready,
  output logic [TAG_W-1:0] fp_tag,
  output logic [15:0]      stall_cycles
);

  localparam logic [1:0] CLS_NOP = 2'b00;
  localparam logic [1:0] CLS_CX  = 2'b01;
  localparam logic [1:0] CLS_FP  = 2'b10;
  localparam logic [1:0] CLS_ANY = 2'b11;

  logic             pend_a_q, pend_b_q;
  logic [1:0]       a_cls_q, b_cls_q;
  logic [TAG_W-1:0] a_tag_q, b_tag_q;

  logic pa, pb;
  logic a_sx, a_cx, a_fp, a_issue;
  logic b_elig, b_sx, b_cx, b_fp, b_issue;
  logic capture;

  // Masking pending bits with rst keeps every output quiet during the reset cycle.
  assign pa = pend_a_q & ~rst;
  assign pb = pend_b_q & ~rst;

  always_comb begin
    a_sx    = pa & (a_cls_q == CLS_ANY);
    a_cx    = pa & (a_cls_q == CLS_CX);
    a_fp    = pa & (a_cls_q == CLS_FP);
    a_issue = (a_sx & sx_ready) | (a_cx & cx_ready) | (a_fp & fp_ready);

    b_elig  = pb & (~pa | a_issue);
    b_sx    = b_elig & (b_cls_q == CLS_ANY) & ~a_sx;
    b_cx    = b_elig & (((b_cls_q == CLS_ANY) & a_sx) | ((b_cls_q == CLS_CX) & ~a_cx));
    b_fp    = b_elig & (b_cls_q == CLS_FP) & ~a_fp;
    b_issue = (b_sx & sx_ready) | (b_cx & cx_ready) | (b_fp & fp_ready);

    in_ready = (~pa | a_issue) & (~pb | b_issue);
    capture  = in_valid & in_ready & ~rst;
  end

  always_comb begin
    sx_valid = a_sx | b_sx;
    cx_valid = a_cx | b_cx;
    fp_valid = a_fp | b_fp;
    sx_tag   = '0;
    cx_tag   = '0;
    fp_tag   = '0;
    if (a_sx)      sx_tag = a_tag_q;
    else if (b_sx) sx_tag = b_tag_q;
    if (a_cx)      cx_tag = a_tag_q;
    else if (b_cx) cx_tag = b_tag_q;
    if (a_fp)      fp_tag = a_tag_q;
    else if (b_fp) fp_tag = b_tag_q;
  end

  // Capture only happens when both slots are empty or emptying, so overwriting is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      a_cls_q  <= CLS_NOP;
      b_cls_q  <= CLS_NOP;
      a_tag_q  <= '0;
      b_tag_q  <= '0;
    end else if (capture) begin
      pend_a_q <= (in_a_class != CLS_NOP);
      pend_b_q <= (in_b_class != CLS_NOP);
      if (in_a_class != CLS_NOP) begin
        a_cls_q <= in_a_class;
        a_tag_q <= in_a_tag;
      end
      if (in_b_class != CLS_NOP) begin
        b_cls_q <= in_b_class;
        b_tag_q <= in_b_tag;
      end
    end else begin
      if (a_issue) pend_a_q <= 1'b0;
      if (b_issue) pend_b_q <= 1'b0;
    end
  end

`ifdef DISPATCH_STALL_CNT_EN
  logic        stalled;
  logic [15:0] stall_q;

  assign stalled = (pa | pb) & ~a_issue & ~b_issue;

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (stalled && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler with per-port expected-tag scoreboards.
module tb_dispatch_scheduler;

  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_a_class, in_b_class;
  logic [TAG_W-1:0] in_a_tag, in_b_tag;
  logic             sx_valid, sx_ready, cx_valid, cx_ready, fp_valid, fp_ready;
  logic [TAG_W-1:0] sx_tag, cx_tag, fp_tag;
  logic [15:0]      stall_cycles;

  int compared   = 0;
  int mismatched = 0;

  logic [TAG_W-1:0] sx_q[$];
  logic [TAG_W-1:0] cx_q[$];
  logic [TAG_W-1:0] fp_q[$];

  dispatch_scheduler #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_class(in_a_class), .in_b_class(in_b_class),
    .in_a_tag(in_a_tag), .in_b_tag(in_b_tag),
    .sx_valid(sx_valid), .sx_ready(sx_ready), .sx_tag(sx_tag),
    .cx_valid(cx_valid), .cx_ready(cx_ready), .cx_tag(cx_tag),
    .fp_valid(fp_valid), .fp_ready(fp_ready), .fp_tag(fp_tag),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  // Drive one pair just after a rising edge; it is captured on the following edge.
  task automatic applyStimulus(input logic v, input logic [1:0] ac, input logic [TAG_W-1:0] at,
                               input logic [1:0] bc, input logic [TAG_W-1:0] bt);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_a_class = ac;
    in_a_tag   = at;
    in_b_class = bc;
    in_b_tag   = bt;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, '0, 2'b00, '0);
  endtask

  task automatic setReady(input logic s, input logic c, input logic f);
    sx_ready = s;
    cx_ready = c;
    fp_ready = f;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic popCheck(input string name, inout logic [TAG_W-1:0] q[$], input logic [TAG_W-1:0] tag);
    logic [TAG_W-1:0] exp_tag;
    if (q.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s unexpected issue observed=%0h expected=none", name, tag);
    end else begin
      exp_tag = q.pop_front();
      checkOutput(name, 16'(tag), 16'(exp_tag));
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (sx_valid && sx_ready) popCheck("sx_issue_tag", sx_q, sx_tag);
      if (cx_valid && cx_ready) popCheck("cx_issue_tag", cx_q, cx_tag);
      if (fp_valid && fp_ready) popCheck("fp_issue_tag", fp_q, fp_tag);
    end
  end

  initial begin
    int exp_stall;
    exp_stall = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a_class = 2'b00; in_b_class = 2'b00;
    in_a_tag = '0; in_b_tag = '0;
    setReady(1'b1, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    sample();
    checkOutput("reset_in_ready", 16'(in_ready), 16'd1);
    checkOutput("reset_valids", {13'd0, sx_valid, cx_valid, fp_valid}, 16'd0);
    checkOutput("reset_tags", 16'(sx_tag | cx_tag | fp_tag), 16'd0);
    checkOutput("reset_stall", stall_cycles, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // A=11/1, B=10/2: simple and FP in the same cycle
    applyStimulus(1'b1, 2'b11, 6'd1, 2'b10, 6'd2);
    sx_q.push_back(6'd1); fp_q.push_back(6'd2);
    sample();
    checkOutput("t1_in_ready_before", 16'(in_ready), 16'd1);
    idle();
    sample();
    checkOutput("t1_valids", {13'd0, sx_valid, cx_valid, fp_valid}, 16'b101);
    checkOutput("t1_in_ready", 16'(in_ready), 16'd1);

    // A=01/3 blocked on cx for 3 cycles, B=11/4 must wait behind it
    applyStimulus(1'b1, 2'b01, 6'd3, 2'b11, 6'd4);
    setReady(1'b1, 1'b0, 1'b1);
    cx_q.push_back(6'd3); sx_q.push_back(6'd4);
    idle();
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("t2_blocked_in_ready", 16'(in_ready), 16'd0);
      checkOutput("t2_blocked_valids", {13'd0, sx_valid, cx_valid, fp_valid}, 16'b010);
      exp_stall++;
      idle();
    end
    setReady(1'b1, 1'b1, 1'b1);
    sample();
    checkOutput("t2_release_valids", {13'd0, sx_valid, cx_valid, fp_valid}, 16'b110);
    checkOutput("t2_release_in_ready", 16'(in_ready), 16'd1);
`ifdef DISPATCH_STALL_CNT_EN
    checkOutput("t2_stall_count", stall_cycles, 16'(exp_stall));
`else
    checkOutput("t2_stall_tied", stall_cycles, 16'd0);
`endif

    // A=11/5, B=11/6: B falls over to complex
    applyStimulus(1'b1, 2'b11, 6'd5, 2'b11, 6'd6);
    sx_q.push_back(6'd5); cx_q.push_back(6'd6);
    idle();
    sample();
    checkOutput("t3_valids", {13'd0, sx_valid, cx_valid, fp_valid}, 16'b110);
    checkOutput("t3_in_ready", 16'(in_ready), 16'd1);

    // A=10/7, B=10/8: FP conflict serialises over two cycles
    applyStimulus(1'b1, 2'b10, 6'd7, 2'b10, 6'd8);
    fp_q.push_back(6'd7); fp_q.push_back(6'd8);
    idle();
    sample();
    checkOutput("t4_first_fp_tag", 16'(fp_tag), 16'd7);
    checkOutput("t4_first_in_ready", 16'(in_ready), 16'd0);
    idle();
    sample();
    checkOutput("t4_second_fp_tag", 16'(fp_tag), 16'd8);
    checkOutput("t4_second_in_ready", 16'(in_ready), 16'd1);
`ifdef DISPATCH_STALL_CNT_EN
    checkOutput("t4_stall_unchanged", stall_cycles, 16'(exp_stall));
`else
    checkOutput("t4_stall_tied", stall_cycles, 16'd0);
`endif

    // A=00, B=01/9: only cx issues; then an all-no-op pair
    applyStimulus(1'b1, 2'b00, 6'd0, 2'b01, 6'd9);
    cx_q.push_back(6'd9);
    idle();
    sample();
    checkOutput("t5_valids", {13'd0, sx_valid, cx_valid, fp_valid}, 16'b010);
    checkOutput("t5_cx_tag", 16'(cx_tag), 16'd9);
    checkOutput("t5_in_ready", 16'(in_ready), 16'd1);
    applyStimulus(1'b1, 2'b00, 6'd12, 2'b00, 6'd13);
    idle();
    sample();
    checkOutput("t5_nop_valids", {13'd0, sx_valid, cx_valid, fp_valid}, 16'b000);
    checkOutput("t5_nop_in_ready", 16'(in_ready), 16'd1);

    // rst while both slots pending discards them
    applyStimulus(1'b1, 2'b01, 6'd10, 2'b01, 6'd11);
    setReady(1'b1, 1'b0, 1'b1);
    idle();
    sample();
    checkOutput("t6_pending_in_ready", 16'(in_ready), 16'd0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    setReady(1'b1, 1'b1, 1'b1);
    sample();
    checkOutput("t6_after_rst_valids", {13'd0, sx_valid, cx_valid, fp_valid}, 16'b000);
    checkOutput("t6_after_rst_in_ready", 16'(in_ready), 16'd1);
    checkOutput("t6_after_rst_stall", stall_cycles, 16'd0);

    repeat (3) idle();
    sample();
    checkOutput("sb_sx_drained", 16'(sx_q.size()), 16'd0);
    checkOutput("sb_cx_drained", 16'(cx_q.size()), 16'd0);
    checkOutput("sb_fp_drained", 16'(fp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
